// File: rtl/subcore_dispatcher.sv
// Fork/join controller: launches selected sub cores with shared PC and per-core args, reports join.
// Latency: accept -> exec_requested 1 cycle; last ended rise -> join_valid 2 cycles; mask=0 -> join 1 cycle.
// Backpressure: fork_ready low while busy; requester holds fork_valid until accepted. Option macro: SUBCORE_TIMEOUT_EN.
module subcore_dispatcher #(
  parameter int NUM_SUB     = 4,
  parameter int PC_W        = 32,
  parameter int ARG_W       = 32,
  parameter int ARM_CYC     = 2,
  parameter int CNT_W       = 16,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     fork_valid,
  output logic                     fork_ready,
  input  logic [PC_W-1:0]          fork_pc,
  input  logic [ARG_W-1:0]         fork_arg,
  input  logic [NUM_SUB-1:0]       fork_mask,
  output logic [NUM_SUB-1:0]       exec_requested,
  output logic [PC_W-1:0]          requested_pc,
  output logic [NUM_SUB*ARG_W-1:0] n_in,
  input  logic [NUM_SUB-1:0]       ended,
  output logic                     busy,
  output logic                     join_valid,
  output logic [CNT_W-1:0]         join_cycles,
  output logic                     join_timeout,
  output logic [NUM_SUB-1:0]       timeout_mask
);

  localparam int AW = (ARM_CYC < 1) ? 1 : $clog2(ARM_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_ARM,
    S_WAIT,
    S_DONE
  } state_t;

  state_t             state;
  logic [NUM_SUB-1:0] mask_q;
  logic [NUM_SUB-1:0] pending;
  logic [NUM_SUB-1:0] pending_nxt;
  logic [NUM_SUB-1:0] ended_q;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_inc;
  logic [AW-1:0]      arm_cnt;
  logic               fork_acc;

  assign fork_acc    = fork_valid & fork_ready;
  // A core only ever leaves pending; a later drop/rise of its ended level is harmless.
  assign pending_nxt = pending & ~ended_q;
  // Join counter saturates instead of wrapping so very long joins still read as "long".
  assign cnt_inc     = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + CNT_W'(1);

`ifdef SUBCORE_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

  logic [WD_W-1:0]    wd;
  logic               join_timeout_q;
  logic [NUM_SUB-1:0] timeout_mask_q;

  assign join_timeout = join_timeout_q;
  assign timeout_mask = timeout_mask_q;
`else
  assign join_timeout = 1'b0;
  assign timeout_mask = '0;
`endif

  // Register ended only while waiting: levels left high by the previous run during
  // LAUNCH/ARM never reach the join logic, and the flop cleanly retimes the input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ended_q <= '0;
    end else if (state == S_WAIT) begin
      ended_q <= ended;
    end else begin
      ended_q <= '0;
    end
  end

  // Fork/join FSM with all outputs registered alongside the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= S_IDLE;
      fork_ready     <= 1'b1;
      busy           <= 1'b0;
      exec_requested <= '0;
      join_valid     <= 1'b0;
      requested_pc   <= '0;
      n_in           <= '0;
      join_cycles    <= '0;
      mask_q         <= '0;
      pending        <= '0;
      cnt            <= '0;
      arm_cnt        <= '0;
`ifdef SUBCORE_TIMEOUT_EN
      wd             <= '0;
      join_timeout_q <= 1'b0;
      timeout_mask_q <= '0;
`endif
    end else begin
      // Pulses default low; each state raises them for exactly one cycle.
      exec_requested <= '0;
      join_valid     <= 1'b0;

      case (state)
        S_IDLE: begin
          if (fork_acc) begin
            requested_pc <= fork_pc;
            mask_q       <= fork_mask;
            for (int i = 0; i < NUM_SUB; i++) begin
              n_in[i*ARG_W +: ARG_W] <= fork_arg + ARG_W'(i);
            end
            join_cycles <= '0;
`ifdef SUBCORE_TIMEOUT_EN
            join_timeout_q <= 1'b0;
            timeout_mask_q <= '0;
`endif
            fork_ready <= 1'b0;
            busy       <= 1'b1;
            if (|fork_mask) begin
              // exec_requested is visible during the LAUNCH cycle.
              exec_requested <= fork_mask;
              state          <= S_LAUNCH;
            end else begin
              // Nothing to launch: complete the join immediately with zero cycles.
              join_valid <= 1'b1;
              state      <= S_DONE;
            end
          end
        end

        S_LAUNCH: begin
          pending <= mask_q;
          cnt     <= CNT_W'(1);
          arm_cnt <= AW'(1);
`ifdef SUBCORE_TIMEOUT_EN
          wd      <= WD_W'(1);
`endif
          state   <= S_ARM;
        end

        S_ARM: begin
          cnt <= cnt_inc;
`ifdef SUBCORE_TIMEOUT_EN
          wd  <= wd + WD_W'(1);
`endif
          if (arm_cnt >= AW'(ARM_CYC)) begin
            state <= S_WAIT;
          end else begin
            arm_cnt <= arm_cnt + AW'(1);
          end
        end

        S_WAIT: begin
          pending <= pending_nxt;
          if (pending_nxt == '0) begin
            // A core ending on the watchdog expiry cycle still counts as a normal join.
            join_valid  <= 1'b1;
            join_cycles <= cnt;
            state       <= S_DONE;
          end
`ifdef SUBCORE_TIMEOUT_EN
          else if (wd >= WD_W'(TIMEOUT_CYC)) begin
            join_valid     <= 1'b1;
            join_cycles    <= cnt;
            join_timeout_q <= 1'b1;
            timeout_mask_q <= pending_nxt;
            state          <= S_DONE;
          end
`endif
          else begin
            cnt <= cnt_inc;
`ifdef SUBCORE_TIMEOUT_EN
            wd  <= wd + WD_W'(1);
`endif
          end
        end

        S_DONE: begin
          fork_ready <= 1'b1;
          busy       <= 1'b0;
          state      <= S_IDLE;
        end

        default: begin
          fork_ready <= 1'b1;
          busy       <= 1'b0;
          state      <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_subcore_dispatcher.sv
// Directed bench for subcore_dispatcher: fork/join timing, masking, stale ended, reset abort.
// Cycle 0 of a fork is the cycle right after the accept edge (exec_requested visible).
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_subcore_dispatcher;

  localparam int NUM_SUB = 4;
  localparam int PC_W    = 32;
  localparam int ARG_W   = 32;
  localparam int CNT_W   = 16;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     fork_valid;
  logic                     fork_ready;
  logic [PC_W-1:0]          fork_pc;
  logic [ARG_W-1:0]         fork_arg;
  logic [NUM_SUB-1:0]       fork_mask;
  logic [NUM_SUB-1:0]       exec_requested;
  logic [PC_W-1:0]          requested_pc;
  logic [NUM_SUB*ARG_W-1:0] n_in;
  logic [NUM_SUB-1:0]       ended;
  logic                     busy;
  logic                     join_valid;
  logic [CNT_W-1:0]         join_cycles;
  logic                     join_timeout;
  logic [NUM_SUB-1:0]       timeout_mask;

  int n_tests = 0;
  int n_fail  = 0;

  subcore_dispatcher #(
    .NUM_SUB    (NUM_SUB),
    .PC_W       (PC_W),
    .ARG_W      (ARG_W),
    .ARM_CYC    (2),
    .CNT_W      (CNT_W),
    .TIMEOUT_CYC(20)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .fork_valid    (fork_valid),
    .fork_ready    (fork_ready),
    .fork_pc       (fork_pc),
    .fork_arg      (fork_arg),
    .fork_mask     (fork_mask),
    .exec_requested(exec_requested),
    .requested_pc  (requested_pc),
    .n_in          (n_in),
    .ended         (ended),
    .busy          (busy),
    .join_valid    (join_valid),
    .join_cycles   (join_cycles),
    .join_timeout  (join_timeout),
    .timeout_mask  (timeout_mask)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one fork and run until join_valid or the budget expires.
  // ended[i] is high in cycles < stale, and from cycle e_i on (e_i < 0: never).
  task automatic run_fork(input logic [3:0] mask, input logic [31:0] pc, input logic [31:0] arg,
                          input int e0, input int e1, input int e2, input int e3,
                          input int stale, input int budget,
                          output int jv_at, output int exec_cnt, output logic [3:0] exec0);
    int ends[4];
    ends      = '{e0, e1, e2, e3};
    jv_at     = -1;
    exec_cnt  = 0;
    exec0     = 4'h0;
    fork_pc   = pc;
    fork_arg  = arg;
    fork_mask = mask;
    fork_valid = 1'b1;
    tick();
    fork_valid = 1'b0;
    for (int c = 0; c <= budget && jv_at < 0; c++) begin
      if (c > 0) tick();
      if (c == 0) exec0 = exec_requested;
      if (exec_requested != 4'h0) exec_cnt++;
      if (join_valid) jv_at = c;
      for (int i = 0; i < 4; i++) begin
        ended[i] = (c < stale) || (ends[i] >= 0 && c >= ends[i]);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int         jv;
    int         ec;
    logic [3:0] e0v;

    rst        = 1'b1;
    fork_valid = 1'b0;
    fork_pc    = '0;
    fork_arg   = '0;
    fork_mask  = '0;
    ended      = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Reset state
    chk("rst_ready", fork_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_exec", exec_requested, 0);
    chk("rst_join_valid", join_valid, 0);
    chk("rst_pc", requested_pc, 0);
    chk("rst_n_in", n_in, 0);
    chk("rst_join_cycles", join_cycles, 0);
    chk("rst_timeout", join_timeout, 0);
    chk("rst_timeout_mask", timeout_mask, 0);

    // 1: all four cores, ends at 5,7,9,6 -> join two cycles after core2 ends
    run_fork(4'b1111, 32'h100, 32'd10, 5, 7, 9, 6, 0, 40, jv, ec, e0v);
    chk("t1_exec0", e0v, 4'b1111);
    chk("t1_exec_once", ec, 1);
    chk("t1_pc", requested_pc, 32'h100);
    chk("t1_n_in", n_in, {32'd13, 32'd12, 32'd11, 32'd10});
    chk("t1_join_at", jv, 11);
    chk("t1_join_cycles", join_cycles, 10);
    chk("t1_ready_in_done", fork_ready, 0);
    chk("t1_busy_in_done", busy, 1);
    tick();
    chk("t1_join_pulse_end", join_valid, 0);
    chk("t1_ready_after", fork_ready, 1);
    chk("t1_busy_after", busy, 0);
    chk("t1_cycles_held", join_cycles, 10);
    chk("t1_no_timeout", join_timeout, 0);

    // 2: cores 1/3 never end but are outside the mask; argument wraps
    run_fork(4'b0101, 32'h2468, 32'hFFFF_FFFF, 4, -1, 6, -1, 0, 40, jv, ec, e0v);
    chk("t2_exec0", e0v, 4'b0101);
    chk("t2_n_in_wrap", n_in, {32'd2, 32'd1, 32'd0, 32'hFFFF_FFFF});
    chk("t2_join_at", jv, 8);
    chk("t2_join_cycles", join_cycles, 7);
    tick();

    // 3: stale ended high through ARM, drops, core0 rises 4 cycles later
    run_fork(4'b0001, 32'h300, 32'd0, 7, -1, -1, -1, 3, 40, jv, ec, e0v);
    chk("t3_join_at", jv, 9);
    chk("t3_join_cycles", join_cycles, 8);
    tick();

    // 4: empty mask -> join immediately, no launch pulse
    run_fork(4'b0000, 32'h400, 32'd5, -1, -1, -1, -1, 0, 10, jv, ec, e0v);
    chk("t4_join_at", jv, 0);
    chk("t4_exec_none", ec, 0);
    chk("t4_join_cycles", join_cycles, 0);
    chk("t4_pc", requested_pc, 32'h400);
    tick();
    chk("t4_ready_after", fork_ready, 1);

    // 5: fork held while busy is ignored, then reset 3 cycles into WAIT aborts
    ended      = '0;
    fork_pc    = 32'h500;
    fork_arg   = 32'd1;
    fork_mask  = 4'b1111;
    fork_valid = 1'b1;
    tick();
    fork_pc = 32'hDEAD;
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (c == 2) chk("t5_busy_ignored_pc", requested_pc, 32'h500);
    end
    fork_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("t5_rst_ready", fork_ready, 1);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_pc", requested_pc, 0);
    chk("t5_rst_n_in", n_in, 0);
    chk("t5_rst_cycles", join_cycles, 0);
    ec = 0;
    ended = 4'b1111;
    repeat (2) begin
      tick();
      if (join_valid) ec++;
    end
    rst = 1'b0;
    repeat (6) begin
      tick();
      if (join_valid || exec_requested != 4'h0) ec++;
    end
    chk("t5_no_pulses", ec, 0);
    ended = '0;

`ifdef SUBCORE_TIMEOUT_EN
    // 6: core3 never ends -> watchdog at 20 cycles
    run_fork(4'b1111, 32'h600, 32'd0, 4, 4, 4, -1, 0, 60, jv, ec, e0v);
    chk("t6_join_at", jv, 21);
    chk("t6_join_cycles", join_cycles, 20);
    chk("t6_timeout", join_timeout, 1);
    chk("t6_timeout_mask", timeout_mask, 4'b1000);
    tick();
    run_fork(4'b0001, 32'h610, 32'd0, 4, -1, -1, -1, 0, 40, jv, ec, e0v);
    chk("t6_next_join_at", jv, 6);
    chk("t6_next_timeout_clr", join_timeout, 0);
    chk("t6_next_mask_clr", timeout_mask, 0);
    tick();
`else
    chk("t6_timeout_tied", join_timeout, 0);
    chk("t6_timeout_mask_tied", timeout_mask, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
